// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - data-bus and IRQ handshake bundle between CPU and interrupt controller
interface irq_controller_if;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq_out;
  logic        irq_ack;
  logic        irq_ret;

  // CPU side drives the bus strobes and the take/return pulses
  modport master (
    output addr, rd, wr, wdata, irq_ack, irq_ret,
    input  rdata, irq_out
  );

  // Controller side answers reads and raises the request
  modport slave (
    input  addr, rd, wr, wdata, irq_ack, irq_ret,
    output rdata, irq_out
  );
endinterface

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-latched, masked, fixed-priority interrupt controller for the single-cycle CPU
// Optional feature macro: IRQC_SYNC_EN (2-flop input synchronizer ahead of edge detect)
module irq_controller #(
  parameter int          N_SRC     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h40000020
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  irq_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state;
  logic [N_SRC-1:0] src_in;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] src_rise;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] pend_next;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] sel_onehot;
  logic [2:0]       sel;
  logic             gen;
  logic             cause_valid;
  logic [2:0]       cause_id;
  logic             irq_r;
  logic             hit;
  logic [1:0]       offset;
  logic             take;
  logic             wr_pend;
  logic             wr_mask;
  logic             wr_ctrl;
  logic             unused_wdata;

`ifdef IRQC_SYNC_EN
  logic [N_SRC-1:0] sync_a;
  logic [N_SRC-1:0] sync_b;

  // Two-flop synchronizer for sources from other clock domains
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= src;
      sync_b <= sync_a;
    end
  end

  assign src_in = sync_b;
`else
  assign src_in = src;
`endif

  assign src_rise = src_in & ~src_q;

  // Window is four aligned words; anything unaligned never decodes
  assign hit    = (bus.addr[31:4] == BASE_ADDR[31:4]) && (bus.addr[1:0] == 2'b00);
  assign offset = bus.addr[3:2];

  assign wr_pend = bus.wr && hit && (offset == 2'd0);
  assign wr_mask = bus.wr && hit && (offset == 2'd1);
  assign wr_ctrl = bus.wr && hit && (offset == 2'd3);

  assign elig       = pend & mask & {N_SRC{gen}};
  // Isolate the lowest set bit: that is the highest-priority eligible source
  assign sel_onehot = elig & (~elig + 1'b1);

  // Encode the winning source index, src[0] wins ties
  always_comb begin
    sel = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) sel = 3'(i);
    end
  end

  // An acknowledge only retires a source when something is actually eligible
  assign take = (state == REQ) && bus.irq_ack && (elig != '0);

  // Pending next value: clears first, then new edges so a fresh edge always survives
  always_comb begin
    pend_next = pend;
    if (wr_pend) pend_next = pend_next & ~bus.wdata[N_SRC-1:0];
    if (take)    pend_next = pend_next & ~sel_onehot;
    pend_next = pend_next | src_rise;
  end

  // Edge history, pending latch, mask and global enable
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= '0;
      pend  <= '0;
      mask  <= '0;
      gen   <= 1'b0;
    end else begin
      src_q <= src_in;
      pend  <= pend_next;
      if (wr_mask) mask <= bus.wdata[N_SRC-1:0];
      if (wr_ctrl) gen  <= bus.wdata[0];
    end
  end

  // Request sequencing with registered irq_out and cause capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      irq_r       <= 1'b0;
      cause_valid <= 1'b0;
      cause_id    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (elig != '0) begin
            state <= REQ;
            irq_r <= 1'b1;
          end
        end
        REQ: begin
          if (bus.irq_ack) begin
            // The CPU has already vectored; go to SERVICE even if the request vanished
            state       <= SERVICE;
            irq_r       <= 1'b0;
            cause_valid <= take;
            cause_id    <= take ? sel : 3'd0;
          end else if (elig == '0) begin
            state <= IDLE;
            irq_r <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.irq_ret) begin
            state       <= IDLE;
            cause_valid <= 1'b0;
            cause_id    <= 3'd0;
          end
        end
        default: begin
          state <= IDLE;
          irq_r <= 1'b0;
        end
      endcase
    end
  end

  // Register read mux; returns zero when not selected
  always_comb begin
    bus.rdata = 32'h0;
    if (bus.rd && hit) begin
      case (offset)
        2'd0:    bus.rdata[N_SRC-1:0] = pend;
        2'd1:    bus.rdata[N_SRC-1:0] = mask;
        2'd2:    bus.rdata = {cause_valid, 28'h0, cause_id};
        2'd3:    bus.rdata[0] = gen;
        default: bus.rdata = 32'h0;
      endcase
    end
  end

  assign bus.irq_out = irq_r;

  assign unused_wdata = &{1'b0, bus.wdata[31:N_SRC]};

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - randomized scoreboard bench for irq_controller against a behavioural model
module tb_irq_controller;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h40000020;
`ifdef IRQC_SYNC_EN
  localparam int SYNC_EXTRA = 2;
`else
  localparam int SYNC_EXTRA = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] src;

  irq_controller_if bus ();

  irq_controller #(.N_SRC(N), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        irq;
    string       tag;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  string section = "init";

  // Behavioural model: sets of pending/enabled sources and a request phase
  typedef enum {M_IDLE, M_ASSERTING, M_IN_HANDLER} mphase_t;
  mphase_t m_phase;
  bit      m_pend[N];
  bit      m_mask[N];
  bit      m_gen;
  bit      m_prev[N];
  bit      m_sync1[N];
  bit      m_sync2[N];
  bit      m_cause_valid;
  int      m_cause_id;

  logic [N-1:0] cur_src = '0;

  function automatic void model_reset();
    m_phase = M_IDLE;
    m_gen = 0;
    m_cause_valid = 0;
    m_cause_id = 0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0; m_sync1[i] = 0; m_sync2[i] = 0;
    end
  endfunction

  function automatic int first_eligible();
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_mask[i] && m_gen) return i;
    return -1;
  endfunction

  function automatic int window_offset(input logic [31:0] a);
    if (a < BASE || a > BASE + 32'd12) return -1;
    if (((a - BASE) % 4) != 0) return -1;
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic r);
    logic [31:0] v;
    int off;
    v = 32'h0;
    off = window_offset(a);
    if (!r || off < 0) return 32'h0;
    case (off)
      0: for (int i = 0; i < N; i++) v[i] = m_pend[i];
      1: for (int i = 0; i < N; i++) v[i] = m_mask[i];
      2: v = (m_cause_valid ? 32'h8000_0000 : 32'h0) + 32'(m_cause_id);
      default: v[0] = m_gen;
    endcase
    return v;
  endfunction

  function automatic void model_step(input logic rst, input logic [N-1:0] s, input logic [31:0] a,
                                     input logic w, input logic [31:0] wd, input logic ack,
                                     input logic ret);
    bit seen[N];
    bit rise[N];
    int e;
    int off;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      seen[i] = (SYNC_EXTRA > 0) ? m_sync2[i] : s[i];
      rise[i] = seen[i] && !m_prev[i];
    end
    e = first_eligible();
    off = w ? window_offset(a) : -1;
    case (m_phase)
      M_IDLE: if (e >= 0) m_phase = M_ASSERTING;
      M_ASSERTING: begin
        if (ack) begin
          m_phase = M_IN_HANDLER;
          if (e >= 0) begin
            m_cause_valid = 1; m_cause_id = e; m_pend[e] = 0;
          end else begin
            m_cause_valid = 0; m_cause_id = 0;
          end
        end else if (e < 0) begin
          m_phase = M_IDLE;
        end
      end
      default: if (ret) begin
        m_phase = M_IDLE; m_cause_valid = 0; m_cause_id = 0;
      end
    endcase
    if (off == 0) for (int i = 0; i < N; i++) if (wd[i]) m_pend[i] = 0;
    if (off == 1) for (int i = 0; i < N; i++) m_mask[i] = wd[i];
    if (off == 3) m_gen = wd[0];
    for (int i = 0; i < N; i++) begin
      if (rise[i]) m_pend[i] = 1;
      m_prev[i]  = seen[i];
      m_sync2[i] = m_sync1[i];
      m_sync1[i] = s[i];
    end
  endfunction

  // One bus cycle: drive, queue the expected response, advance the model
  task automatic cyc(input logic rst, input logic [31:0] a, input logic r, input logic w,
                     input logic [31:0] wd, input logic ack, input logic ret,
                     input bit use_const, input logic [31:0] const_val);
    exp_t ex;
    reset = rst; src = cur_src;
    bus.addr = a; bus.rd = r; bus.wr = w; bus.wdata = wd;
    bus.irq_ack = ack; bus.irq_ret = ret;
    ex.rdata = use_const ? const_val : model_read(a, r);
    ex.irq   = (m_phase == M_ASSERTING);
    ex.tag   = $sformatf("%s/cyc%0d", section, cyc_no);
    sb.push_back(ex);
    model_step(rst, cur_src, a, w, wd, ack, ret);
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, BASE + 32'(4 * (i % 4)), 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wreg(input int off, input logic [31:0] d);
    cyc(0, BASE + 32'(4 * off), 0, 1, d, 0, 0, 0, 0);
  endtask

  task automatic expect_reg(input int off, input logic [31:0] v);
    cyc(0, BASE + 32'(4 * off), 1, 0, 0, 0, 0, 1, v);
  endtask

  task automatic ack_pulse();
    cyc(0, BASE, 1, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic ret_pulse();
    cyc(0, BASE, 1, 0, 0, 0, 1, 0, 0);
  endtask

  // Monitor: pops one expectation per cycle and compares at mid-cycle
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        n_checks++;
        if (bus.rdata !== ex.rdata) begin
          n_fail++;
          $display("FAIL %s rdata: got %h expected %h", ex.tag, bus.rdata, ex.rdata);
        end
        n_checks++;
        if (bus.irq_out !== ex.irq) begin
          n_fail++;
          $display("FAIL %s irq_out: got %b expected %b", ex.tag, bus.irq_out, ex.irq);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [31:0] a, wd;
    logic rd_b, wr_b, ack_b, ret_b, rst_b;

    reset = 1; src = '0;
    bus.addr = '0; bus.rd = 0; bus.wr = 0; bus.wdata = '0; bus.irq_ack = 0; bus.irq_ret = 0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();

    section = "reset";
    expect_reg(0, 32'h0); expect_reg(1, 32'h0); expect_reg(2, 32'h0); expect_reg(3, 32'h0);

    section = "t1";
    wreg(1, 32'hF); wreg(3, 32'h1);
    cur_src = 4'b0100;
    idle(SYNC_EXTRA);
    expect_reg(0, 32'h0);
    expect_reg(0, 32'h4);
    idle(1);

    section = "t2";
    ack_pulse();
    expect_reg(2, 32'h8000_0002);
    expect_reg(0, 32'h0);
    ret_pulse();
    expect_reg(2, 32'h0);

    section = "t3";
    cur_src = 4'b0000; idle(1 + SYNC_EXTRA);
    cur_src = 4'b1010; idle(2 + SYNC_EXTRA);
    ack_pulse();
    expect_reg(2, 32'h8000_0001);
    ret_pulse();
    idle(2);
    ack_pulse();
    expect_reg(2, 32'h8000_0003);
    ret_pulse();

    section = "t4";
    cur_src = 4'b0000; idle(1 + SYNC_EXTRA);
    wreg(1, 32'h0);
    cur_src = 4'b0001; idle(2 + SYNC_EXTRA);
    expect_reg(0, 32'h1);
    wreg(1, 32'h1);
    idle(2);
    wreg(0, 32'h1);
    idle(2);
    expect_reg(0, 32'h0);

    section = "t5";
    cur_src = 4'b0000; idle(1 + SYNC_EXTRA);
    wreg(1, 32'h0);
    cur_src = 4'b0001; idle(1 + SYNC_EXTRA);
    cur_src = 4'b0000; idle(1 + SYNC_EXTRA);
    cur_src = 4'b0001; idle(SYNC_EXTRA);
    wreg(0, 32'h1);
    expect_reg(0, 32'h1);
    wreg(0, 32'h1);
    wreg(1, 32'hF);

    section = "t6";
    cur_src = 4'b0000; idle(1 + SYNC_EXTRA);
    cur_src = 4'b0100; idle(2 + SYNC_EXTRA);
    ack_pulse();
    cur_src = 4'b0000;
    cyc(1, BASE, 1, 0, 0, 0, 0, 0, 0);
    expect_reg(0, 32'h0); expect_reg(1, 32'h0); expect_reg(2, 32'h0); expect_reg(3, 32'h0);
    wreg(1, 32'hF); wreg(3, 32'h1);
    cur_src = 4'b0100; idle(2 + SYNC_EXTRA);
    ack_pulse();
    expect_reg(2, 32'h8000_0002);
    ret_pulse();

    section = "rand";
    for (int k = 0; k < 2000; k++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 99) < 12) cur_src[b] = ~cur_src[b];
      r = $urandom_range(0, 99);
      if (r < 70)      a = BASE + 32'(4 * $urandom_range(0, 3));
      else if (r < 78) a = BASE + 32'($urandom_range(1, 3));
      else if (r < 86) a = BASE + 32'd16;
      else if (r < 92) a = BASE - 32'd4;
      else             a = $urandom;
      rd_b  = ($urandom_range(0, 99) < 70);
      wr_b  = ($urandom_range(0, 99) < 15);
      wd    = $urandom;
      if ($urandom_range(0, 99) < 80) wd[0] = 1'b1;
      ack_b = ($urandom_range(0, 99) < ((m_phase == M_ASSERTING) ? 35 : 5));
      ret_b = ($urandom_range(0, 99) < ((m_phase == M_IN_HANDLER) ? 25 : 5));
      rst_b = ($urandom_range(0, 999) < 5);
      cyc(rst_b, a, rd_b, wr_b, wd, ack_b, ret_b, 0, 0);
    end

    @(negedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
